morse_symbol_capture: RTL and testbench

Parametrised successor to the single-letter Morse reader. It times a debounced key in prescaled ticks and classifies each press as dot, dash or reject. Symbols are accumulated into a variable-length character with delete and commit support. Completed characters are handed downstream to the Morse-to-ASCII stage over a valid/ready interface, with sticky error reporting.

---
 rtl/morse_pkg.sv | 29 ++
 rtl/morse_tick_timer.sv | 49 ++++
 rtl/morse_symbol_capture.sv | 211 +++++++++++++++++++++
 tb/tb_morse_symbol_capture.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared types and constants for the Morse symbol capture block.
// Holds the capture FSM state encoding, symbol values, error flag bit
// positions and the width helpers used to size counters.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } morse_state_e;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int ERR_REJECT   = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_DROPPED  = 2;

  // Bits needed to hold any value 0..max_value.
  function automatic int count_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

  // Bits needed for a prescaler that counts 0..div-1 (at least one bit).
  function automatic int div_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/morse_tick_timer.sv
// morse_tick_timer: prescaler producing one tick every TICK_DIV clocks, plus a
// counter of those ticks that saturates at SAT. The prescaler can be
// restarted so tick phase is aligned to an external event (a key edge).
module morse_tick_timer
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 5000,
  parameter int SAT      = 7001,
  parameter int W        = count_width(SAT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  localparam int             PW         = div_width(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]   COUNT_SAT  = W'(SAT);

  logic [PW-1:0] presc;
  logic          tick;

  // A restart cycle never ticks, so the first tick lands a full period later.
  assign tick = !restart && (presc == PRESC_LAST);

  // Prescaler: counts 0..TICK_DIV-1, back to 0 on wrap or restart.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (rst || restart || (presc == PRESC_LAST)) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Tick counter: clear dominates, then counts enabled ticks up to SAT.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && tick && (count != COUNT_SAT)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/morse_symbol_capture.sv
// morse_symbol_capture: times a debounced key in prescaled ticks, classifies
// each press as dot, dash or reject, accumulates a variable-length character
// with delete/commit, and hands finished characters downstream via
// valid/ready with sticky error flags.
// Optional build macro: MORSE_AUTO_COMMIT_EN -- commit automatically after
// CHAR_GAP idle ticks following the last release.
module morse_symbol_capture
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 6,
  parameter int TICK_DIV    = 5000,
  parameter int DOT_MAX     = 2000,
  parameter int DASH_MIN    = 4000,
  parameter int DASH_MAX    = 7000,
  parameter int CHAR_GAP    = 9000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key,
  input  logic                             del_pulse,
  input  logic                             fin_pulse,
  output logic                             char_valid,
  input  logic                             char_ready,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0] char_len,
  output logic [MAX_SYMBOLS-1:0]           char_pattern,
  output logic                             cls_short,
  output logic                             cls_long,
  output logic                             cls_null,
  output logic                             sym_pulse,
  output logic [2:0]                       err_flags
);

  localparam int                 LEN_W      = count_width(MAX_SYMBOLS);
  localparam int                 PRESS_W    = count_width(DASH_MAX + 1);
  localparam logic [LEN_W-1:0]   LEN_MAX    = LEN_W'(MAX_SYMBOLS);
  localparam logic [PRESS_W-1:0] DOT_MAX_C  = PRESS_W'(DOT_MAX);
  localparam logic [PRESS_W-1:0] DASH_MIN_C = PRESS_W'(DASH_MIN);
  localparam logic [PRESS_W-1:0] DASH_MAX_C = PRESS_W'(DASH_MAX);

  // Reject inconsistent timing configurations at elaboration.
  if (MAX_SYMBOLS < 2 || TICK_DIV < 1 || DASH_MIN <= DOT_MAX ||
      DASH_MAX < DASH_MIN || CHAR_GAP < 1) begin : g_bad_params
    $error("morse_symbol_capture: inconsistent parameter set");
  end

  morse_state_e           state, state_d;
  logic                   key_q, rise, fall, rel_q;
  logic [PRESS_W-1:0]     press_cnt, cur_cnt;
  logic                   is_dot, is_dash, commit_req, auto_commit, load_out;
  logic [LEN_W-1:0]       len, len_mid, len_d;
  logic [MAX_SYMBOLS-1:0] pat, pat_mid, pat_d;
  logic [2:0]             err_d;
  logic                   sym_d;

  assign rise = key & ~key_q;
  assign fall = ~key & key_q;

  // Track the key level and flag a finished press for classification next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // key_q starts high so a key already held through reset is not seen as
      // a fresh press; its later release is ignored because the FSM is IDLE.
      key_q <= 1'b1;
      rel_q <= 1'b0;
    end else begin
      key_q <= key;
      rel_q <= fall && (state == PRESS);
    end
  end

  morse_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .SAT      (DASH_MAX + 1),
    .W        (PRESS_W)
  ) u_press_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (rise | fall),
    .clear   (rise),
    .enable  (key),
    .count   (press_cnt)
  );

`ifdef MORSE_AUTO_COMMIT_EN
  localparam int GAP_W = count_width(CHAR_GAP);
  logic [GAP_W-1:0] gap_cnt;

  morse_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .SAT      (CHAR_GAP),
    .W        (GAP_W)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (rise | fall),
    .clear   (state != GAP),
    .enable  (1'b1),
    .count   (gap_cnt)
  );

  // Fires once per gap: the commit it raises moves the FSM out of GAP,
  // which clears the gap counter.
  assign auto_commit = (state == GAP) && (gap_cnt == GAP_W'(CHAR_GAP));
`else
  assign auto_commit = 1'b0;
`endif

  assign commit_req = fin_pulse | auto_commit;

  // The rise cycle still shows the previous press count; treat it as zero.
  assign cur_cnt = rise ? '0 : press_cnt;
  assign is_dot  = (press_cnt != '0) && (press_cnt <= DOT_MAX_C);
  assign is_dash = (press_cnt >= DASH_MIN_C) && (press_cnt <= DASH_MAX_C);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next state: a new press wins over a commit arriving in the same cycle.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    state_d = state;
    unique case (state)
      IDLE:    if (rise) state_d = PRESS;
      PRESS:   if (fall) state_d = GAP;
      GAP: begin
        if (rise)            state_d = PRESS;
        else if (commit_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator update: delete beats append, then a commit captures the result.
  always_comb begin
    len_mid  = len;
    pat_mid  = pat;
    err_d    = err_flags;
    sym_d    = 1'b0;
    load_out = 1'b0;

    if (rel_q && !(is_dot || is_dash)) begin
      err_d[ERR_REJECT] = 1'b1;
    end

    if (del_pulse && (len != '0)) begin
      len_mid = len - LEN_W'(1);
      pat_mid = pat >> 1;
    end else if (rel_q && (is_dot || is_dash)) begin
      if (len == LEN_MAX) begin
        err_d[ERR_OVERFLOW] = 1'b1;
      end else begin
        len_mid = len + LEN_W'(1);
        pat_mid = {pat[MAX_SYMBOLS-2:0], (is_dash ? SYM_DASH : SYM_DOT)};
        sym_d   = 1'b1;
      end
    end

    len_d = len_mid;
    pat_d = pat_mid;
    if (commit_req && (len_mid != '0)) begin
      if (!char_valid || char_ready) begin
        load_out            = 1'b1;
        len_d               = '0;
        pat_d               = '0;
        err_d[ERR_REJECT]   = 1'b0;
        err_d[ERR_OVERFLOW] = 1'b0;
      end else begin
        err_d[ERR_DROPPED] = 1'b1;
      end
    end
  end

  // Accumulator, error, output record and live classification registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len          <= '0;
      pat          <= '0;
      err_flags    <= '0;
      sym_pulse    <= 1'b0;
      char_valid   <= 1'b0;
      char_len     <= '0;
      char_pattern <= '0;
      cls_short    <= 1'b0;
      cls_long     <= 1'b0;
      cls_null     <= 1'b0;
    end else begin
      len       <= len_d;
      pat       <= pat_d;
      err_flags <= err_d;
      sym_pulse <= sym_d;
      if (load_out) begin
        char_valid   <= 1'b1;
        char_len     <= len_mid;
        char_pattern <= pat_mid;
      end else if (char_ready) begin
        char_valid <= 1'b0;
      end
      cls_short <= key && (cur_cnt <= DOT_MAX_C);
      cls_long  <= key && (cur_cnt >= DASH_MIN_C) && (cur_cnt <= DASH_MAX_C);
      cls_null  <= key && (cur_cnt > DASH_MAX_C);
    end
  end

endmodule

// File: tb/tb_morse_symbol_capture.sv
// tb_morse_symbol_capture: directed and randomized checks of
// morse_symbol_capture against a queue-based model of the character
// accumulator. Define MORSE_AUTO_COMMIT_EN to also exercise auto-commit.
module tb_morse_symbol_capture;

  localparam int MAXS     = 6;
  localparam int TICK_DIV = 1;
  localparam int DOT_MAX  = 3;
  localparam int DASH_MIN = 6;
  localparam int DASH_MAX = 10;
  localparam int CHAR_GAP = 15;

  logic            clk = 1'b0;
  logic            rst, key, del_pulse, fin_pulse, char_ready;
  logic            char_valid, cls_short, cls_long, cls_null, sym_pulse;
  logic [2:0]      char_len;
  logic [MAXS-1:0] char_pattern;
  logic [2:0]      err_flags;

  morse_symbol_capture #(
    .MAX_SYMBOLS (MAXS),
    .TICK_DIV    (TICK_DIV),
    .DOT_MAX     (DOT_MAX),
    .DASH_MIN    (DASH_MIN),
    .DASH_MAX    (DASH_MAX),
    .CHAR_GAP    (CHAR_GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key          (key),
    .del_pulse    (del_pulse),
    .fin_pulse    (fin_pulse),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .char_len     (char_len),
    .char_pattern (char_pattern),
    .cls_short    (cls_short),
    .cls_long     (cls_long),
    .cls_null     (cls_null),
    .sym_pulse    (sym_pulse),
    .err_flags    (err_flags)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the accumulated character as a queue of symbols
  // (push_back = newest), plus the output record and error flags.
  bit              m_acc[$];
  bit              m_valid;
  bit              m_load;
  int              m_out_len;
  logic [MAXS-1:0] m_out_pat;
  logic [2:0]      m_err;
  int              m_syms;
  int              sym_seen = 0;

  always @(negedge clk) if (sym_pulse === 1'b1) sym_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAXS-1:0] acc_pattern();
    logic [MAXS-1:0] p;
    p = '0;
    for (int i = 0; i < m_acc.size(); i++) p[i] = m_acc[m_acc.size()-1-i];
    return p;
  endfunction

  // Expected live class for a running press count.
  function automatic logic [2:0] cls_of(input int c);
    return {c <= DOT_MAX, (c >= DASH_MIN) && (c <= DASH_MAX), c > DASH_MAX};
  endfunction

  // Advance clock edges, keeping the model's output-valid bit in step with
  // the handshake: a pending load sets it, otherwise acceptance clears it.
  task automatic tick_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (m_load) begin
        m_valid = 1'b1;
        m_load  = 1'b0;
      end else if (char_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Hold the key for 'cycles' clocks, release, and optionally request a
  // delete in the cycle the release is classified. The rise cycle restarts
  // the prescaler, so a press held c cycles accumulates (c-1)/TICK_DIV ticks.
  task automatic press(input int cycles, input bit del_at_classify);
    int  cnt;
    bit  ok;
    key = 1'b1;
    tick_cycles(cycles);
    key = 1'b0;
    tick_cycles(1);
    del_pulse = del_at_classify;
    tick_cycles(1);
    del_pulse = 1'b0;
    cnt = (cycles - 1) / TICK_DIV;
    if (cnt > DASH_MAX + 1) cnt = DASH_MAX + 1;
    ok = ((cnt >= 1) && (cnt <= DOT_MAX)) || ((cnt >= DASH_MIN) && (cnt <= DASH_MAX));
    if (!ok) m_err[0] = 1'b1;
    if (del_at_classify && (m_acc.size() > 0)) begin
      void'(m_acc.pop_back());
    end else if (ok) begin
      if (m_acc.size() == MAXS) begin
        m_err[1] = 1'b1;
      end else begin
        m_acc.push_back(cnt >= DASH_MIN);
        m_syms++;
      end
    end
  endtask

  task automatic del_sym();
    del_pulse = 1'b1;
    tick_cycles(1);
    del_pulse = 1'b0;
    if (m_acc.size() > 0) void'(m_acc.pop_back());
  endtask

  // Commit request, optionally with a delete in the same cycle.
  task automatic fin(input bit with_del);
    if (with_del && (m_acc.size() > 0)) void'(m_acc.pop_back());
    if (m_acc.size() > 0) begin
      if (!m_valid || char_ready) begin
        m_out_len = m_acc.size();
        m_out_pat = acc_pattern();
        m_acc.delete();
        m_err[1:0] = 2'b00;
        m_load = 1'b1;
      end else begin
        m_err[2] = 1'b1;
      end
    end
    fin_pulse = 1'b1;
    del_pulse = with_del;
    tick_cycles(1);
    fin_pulse = 1'b0;
    del_pulse = 1'b0;
  endtask

  task automatic check_out(input string tag);
    check({tag, "_valid"}, char_valid, m_valid);
    check({tag, "_len"}, char_len, m_out_len);
    check({tag, "_pat"}, char_pattern, m_out_pat);
    check({tag, "_err"}, err_flags, m_err);
  endtask

  task automatic model_reset();
    m_acc.delete();
    m_valid   = 1'b0;
    m_load    = 1'b0;
    m_out_len = 0;
    m_out_pat = '0;
    m_err     = '0;
  endtask

  initial begin
    int n_press;
    int waited;
    int rises;
    rst        = 1'b1;
    key        = 1'b0;
    del_pulse  = 1'b0;
    fin_pulse  = 1'b0;
    char_ready = 1'b1;
    m_syms     = 0;
    model_reset();
    tick_cycles(2);

    // Reset state.
    check("rst_valid", char_valid, 0);
    check("rst_len", char_len, 0);
    check("rst_pat", char_pattern, 0);
    check("rst_err", err_flags, 0);
    check("rst_cls", {cls_short, cls_long, cls_null}, 0);
    check("rst_sym", sym_pulse, 0);
    rst = 1'b0;
    tick_cycles(1);

    // 1: dot, dash, dot then commit -> len 3, pattern 000010.
    press(3, 1'b0);
    press(9, 1'b0);
    press(3, 1'b0);
    fin(1'b0);
    check_out("t1");
    check("t1_pat_const", char_pattern, 6'b000010);
    check("t1_syms", sym_seen, 3);
    tick_cycles(1);
    check("t1_valid_drop", char_valid, m_valid);

    // 2: 5-tick and 12-tick presses are rejected; live class follows the press.
    press(6, 1'b0);
    key = 1'b1;
    tick_cycles(2);
    check("t2_cls_short", {cls_short, cls_long, cls_null}, cls_of(0));
    tick_cycles(6);
    check("t2_cls_long", {cls_short, cls_long, cls_null}, cls_of(6));
    tick_cycles(5);
    check("t2_cls_null", {cls_short, cls_long, cls_null}, cls_of(11));
    key = 1'b0;
    tick_cycles(1);
    check("t2_cls_released", {cls_short, cls_long, cls_null}, 3'b000);
    tick_cycles(1);
    m_err[0] = 1'b1;
    check("t2_err", err_flags, m_err);
    check("t2_syms", sym_seen, m_syms);
    fin(1'b0);
    check_out("t2_empty_commit");

    // 3: seven dots overflow, delete one, commit five.
    for (int i = 0; i < 7; i++) press(3, 1'b0);
    check("t3_err_ovf", err_flags, m_err);
    del_sym();
    fin(1'b0);
    check_out("t3");
    // Delete in the classify cycle beats the append.
    press(3, 1'b0);
    press(9, 1'b1);
    fin(1'b0);
    tick_cycles(1);
    check_out("t3_del_vs_app");

    // 4: stalled output drops the second commit, then a ready-cycle commit reloads.
    char_ready = 1'b0;
    press(9, 1'b0);
    fin(1'b0);
    check_out("t4_first");
    press(9, 1'b0);
    press(9, 1'b0);
    fin(1'b0);
    check_out("t4_dropped");
    char_ready = 1'b1;
    fin(1'b0);
    check_out("t4_second");
    check("t4_pat_const", char_pattern, 6'b000011);
    tick_cycles(1);

    // 5: reset during a press with three symbols held.
    for (int i = 0; i < 3; i++) press(3, 1'b0);
    key = 1'b1;
    tick_cycles(4);
    rst = 1'b1;
    tick_cycles(1);
    model_reset();
    check_out("t5_rst");
    check("t5_cls", {cls_short, cls_long, cls_null}, 3'b000);
    check("t5_sym", sym_pulse, 0);
    rst = 1'b0;
    tick_cycles(3);
    key = 1'b0;
    tick_cycles(3);
    check("t5_no_append", sym_seen, m_syms);
    fin(1'b0);
    check_out("t5_empty");

    // Randomized characters with random ready, deletes and commit+delete.
    for (int r = 0; r < 24; r++) begin
      char_ready = ($urandom_range(0, 3) != 0);
      n_press = $urandom_range(1, 7);
      for (int k = 0; k < n_press; k++) press($urandom_range(1, 14), 1'b0);
      if ($urandom_range(0, 2) == 0) del_sym();
      fin($urandom_range(0, 3) == 0);
      check_out($sformatf("rnd%0d", r));
    end
    char_ready = 1'b1;
    tick_cycles(1);
    check("rnd_syms", sym_seen, m_syms);

`ifdef MORSE_AUTO_COMMIT_EN
    // 6: one dot, then an idle gap commits it automatically, exactly once.
    fin(1'b0);
    tick_cycles(1);
    press(3, 1'b0);
    waited = 0;
    while (!char_valid && waited < 4 * CHAR_GAP) begin
      tick_cycles(1);
      waited++;
    end
    check("t6_auto_seen", char_valid, 1);
    check("t6_gap_time", (waited >= CHAR_GAP - 3) && (waited <= CHAR_GAP + 2), 1);
    m_out_len = m_acc.size();
    m_out_pat = acc_pattern();
    m_acc.delete();
    m_err[1:0] = 2'b00;
    m_valid = 1'b1;
    check_out("t6_auto");
    rises = 0;
    for (int i = 0; i < 3 * CHAR_GAP; i++) begin
      tick_cycles(1);
      if (char_valid) rises++;
    end
    check("t6_single", rises, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
